wash_run: RTL and testbench
===========================

// Module: wash_run
// PURPOSE
//  Wash-stage controller: consumer end of the pre-wash setup interface (is_on/bal/mode/minutes).
//  Accepts a configured job on the confirm button and charges the cycle price from the balance.
//  Then counts the cycle down in BCD mm:ss, supports pause/abort with partial refund, and raises a timed alarm on finish or rejection.
//  Drives the right display digits and the 3 status LEDs while active.
// PARAMETERS
//  TICK_CYC   100_000_000  clk cycles per countdown second (override small in sim)
//  ALARM_CYC  250_000_000  clk cycles the alarm stays asserted (2.5 s)
// PORTS
//  clk        in   1   system clock; the only clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   confirm-button pulse (1 clk, already debounced)
//  pause      in   1   pause/resume pulse (1 clk)
//  abort      in   1   abort pulse (1 clk)
//  is_on      in   1   setup stage reports job valid
//  bal_in     in   11  signed balance from setup, 0..999
//  mode       in   2   wash mode 0..3
//  minutes    in   5   cycle length in minutes, binary, legal 1..29
//  bal_out    out  11  signed balance after charge/refund
//  busy       out  1   high in RUN or PAUSE
//  done       out  1   1-clk pulse when countdown reaches 00:00
//  alarm      out  1   high ALARM_CYC cycles after done or reject
//  reject     out  1   1-clk pulse when start refused
//  digits     out  16  BCD {min_t,min_o,sec_t,sec_o}; 4'hb = blank nibble
//  st_light   out  3   001 IDLE, 010 RUN, 100 PAUSE, 111 ALARM
// BEHAVIOUR
//  Reset: state=IDLE, bal_out=0, busy=0, done=0, alarm=0, reject=0, digits=16'hbbbb, st_light=001,
//   prescaler=0, alarm counter=0. Reset mid-run discards the job; no refund.
//  Price per minute: mode0=1, mode1=2, mode2=3, mode3=5. cost=price*minutes, 0..145, compute in 11 bits, no overflow.
//  IDLE: on start:
//   accept iff is_on && minutes in 1..29 && cost <= bal_in.
//    Accept: next clk bal_out<=bal_in-cost, digits<=BCD(minutes):00, prescaler<=0, state RUN.
//    Otherwise: reject pulse next clk, alarm counter loaded, state ALARM, bal_out unchanged.
//   pause/abort ignored in IDLE.
//  RUN: prescaler counts 0..TICK_CYC-1; at wrap decrement mm:ss by 1 s (BCD borrow: sec_o 0->9 with sec_t--,
//   sec_t 0->5 with min_o--, min_o 0->9 with min_t--). When the decrement yields 00:00: done pulse that same
//   clk edge, state ALARM, alarm counter loaded. First decrement occurs TICK_CYC clks after acceptance.
//  Priority within a cycle: abort > pause > tick.
//  PAUSE: pause pulse in RUN -> PAUSE; prescaler and digits frozen; next pause -> RUN resuming prescaler value.
//  Abort in RUN/PAUSE: refund price*(whole minutes remaining, i.e. min_t*10+min_o; seconds not refunded),
//   bal_out+=refund, digits<=hbbbb, state IDLE. Abort coinciding with final tick: abort wins, no done.
//  ALARM: alarm=1 for exactly ALARM_CYC clks, then IDLE, digits<=hbbbb. start/pause/abort ignored.
//  Outputs registered; busy/st_light decode the registered state; done/reject high exactly one clk.
//  bal_out never negative; balance is not re-read from bal_in except on accept.
// TESTING (TICK_CYC=4, ALARM_CYC=6)
//  1 accept: bal_in=50, mode=1, minutes=3, is_on=1, start -> bal_out=44, digits=16'h0300, busy=1, st_light=010.
//  2 countdown: continue case 1 -> after 4 clks digits=0259. At 00:00: done one clk, alarm 6 clks, then IDLE/hbbbb.
//  3 reject: bal_in=10, mode=3, minutes=3 (cost 15) -> reject pulse, bal_out unchanged, alarm 6 clks, no busy.
//    Also minutes=0 or is_on=0 -> reject.
//  4 pause: mid-run pause -> digits/prescaler frozen 20 clks, st_light=100; resume -> next tick after remaining prescale.
//  5 abort: mode=2, minutes=10, bal 100 -> 70; abort at 07:xx -> bal_out=91, IDLE.
//    Abort+pause same clk -> abort taken.
//  6 reset mid-RUN -> next clk all outputs at reset values, bal_out=0.

Source files
------------

// File: rtl/wash_run.sv
// wash_run: wash-stage controller.
// Takes a configured job from the setup stage when the confirm button is pressed,
// charges the cycle price, counts the cycle down in BCD mm:ss, supports
// pause/resume and abort with a refund of whole remaining minutes, and holds
// an alarm for a fixed time after completion or a refused start.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, pause, abort   single-cycle button pulses
//   is_on                 setup stage reports a valid job
//   bal_in  [10:0]        signed balance from setup (sampled only on accept)
//   mode    [1:0]         wash mode, selects price per minute
//   minutes [4:0]         cycle length in minutes, legal 1..29
//   bal_out [10:0]        balance after charge/refund
//   busy                  high in RUN or PAUSE
//   done                  one-cycle pulse when the countdown reaches 00:00
//   alarm                 high while in the ALARM state
//   reject                one-cycle pulse when a start is refused
//   digits  [15:0]        BCD {min_t,min_o,sec_t,sec_o}; 4'hb nibble = blank
//   st_light [2:0]        001 IDLE, 010 RUN, 100 PAUSE, 111 ALARM (state view)
//
// Handshake: there is no valid/ready flow here. Every input pulse is a
// single-cycle event sampled on the rising clock edge; it is acted on only in
// states that accept it and silently dropped otherwise.
module wash_run #(
   parameter int TICK_CYC  = 100_000_000,
   parameter int ALARM_CYC = 250_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        abort,
   input  logic        is_on,
   input  logic [10:0] bal_in,
   input  logic [1:0]  mode,
   input  logic [4:0]  minutes,
   output logic [10:0] bal_out,
   output logic        busy,
   output logic        done,
   output logic        alarm,
   output logic        reject,
   output logic [15:0] digits,
   output logic [2:0]  st_light
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_e;

   localparam logic [31:0] TICK_LAST  = 32'(TICK_CYC - 1);
   localparam logic [31:0] ALARM_LAST = 32'(ALARM_CYC - 1);
   localparam logic [15:0] BLANK      = 16'hbbbb;

   state_e      state_q, state_d;
   logic [31:0] presc_q, presc_d;
   logic [31:0] alarm_cnt_q, alarm_cnt_d;
   logic [15:0] digits_q, digits_d;
   logic [10:0] bal_q, bal_d;
   logic [1:0]  mode_q, mode_d;
   logic        done_q, done_d;
   logic        reject_q, reject_d;

   logic [10:0] cost, rem_min, refund;
   logic [3:0]  min_t_in, min_o_in;
   logic [15:0] dec_val;
   logic        accept_ok;

   function automatic logic [2:0] price(input logic [1:0] m);
      case (m)
         2'd0:    price = 3'd1;
         2'd1:    price = 3'd2;
         2'd2:    price = 3'd3;
         default: price = 3'd5;
      endcase
   endfunction

   // One-second BCD decrement with borrow; never called on 00:00.
   function automatic logic [15:0] dec_bcd(input logic [15:0] d);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = d;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      dec_bcd = {mt, mo, st, so};
   endfunction

   always_comb begin
      // Binary minutes -> BCD tens/ones; only 0..29 ever reaches the display.
      min_t_in = 4'd0;
      min_o_in = 4'(minutes);
      if (minutes >= 5'd20) begin
         min_t_in = 4'd2;
         min_o_in = 4'(minutes - 5'd20);
      end else if (minutes >= 5'd10) begin
         min_t_in = 4'd1;
         min_o_in = 4'(minutes - 5'd10);
      end
      cost      = {8'd0, price(mode)} * {6'd0, minutes};
      // cost is at most 155, so it is non-negative as a signed 11-bit value.
      accept_ok = is_on && (minutes != 5'd0) && (minutes <= 5'd29) &&
                  ($signed(cost) <= $signed(bal_in));
      // Refund uses the mode captured at accept, not the live mode input.
      rem_min   = {7'd0, digits_q[15:12]} * 11'd10 + {7'd0, digits_q[11:8]};
      refund    = {8'd0, price(mode_q)} * rem_min;
      dec_val   = dec_bcd(digits_q);
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      alarm_cnt_d = alarm_cnt_q;
      digits_d    = digits_q;
      bal_d       = bal_q;
      mode_d      = mode_q;
      done_d      = 1'b0;
      reject_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (accept_ok) begin
                  bal_d    = bal_in - cost;
                  digits_d = {min_t_in, min_o_in, 8'h00};
                  presc_d  = 32'd0;
                  mode_d   = mode;
                  state_d  = S_RUN;
               end else begin
                  reject_d    = 1'b1;
                  alarm_cnt_d = ALARM_LAST;
                  state_d     = S_ALARM;
               end
            end
         end
         S_RUN: begin
            // abort beats pause beats the tick.
            if (abort) begin
               bal_d    = bal_q + refund;
               digits_d = BLANK;
               state_d  = S_IDLE;
            end else if (pause) begin
               state_d = S_PAUSE;
            end else if (presc_q == TICK_LAST) begin
               presc_d  = 32'd0;
               digits_d = dec_val;
               if (dec_val == 16'h0000) begin
                  done_d      = 1'b1;
                  alarm_cnt_d = ALARM_LAST;
                  state_d     = S_ALARM;
               end
            end else begin
               presc_d = presc_q + 32'd1;
            end
         end
         S_PAUSE: begin
            if (abort) begin
               bal_d    = bal_q + refund;
               digits_d = BLANK;
               state_d  = S_IDLE;
            end else if (pause) begin
               state_d = S_RUN;
            end
         end
         default: begin
            // Counter is loaded with ALARM_CYC-1 so ALARM lasts ALARM_CYC cycles.
            if (alarm_cnt_q == 32'd0) begin
               digits_d = BLANK;
               state_d  = S_IDLE;
            end else begin
               alarm_cnt_d = alarm_cnt_q - 32'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         presc_q     <= 32'd0;
         alarm_cnt_q <= 32'd0;
         digits_q    <= BLANK;
         bal_q       <= 11'd0;
         mode_q      <= 2'd0;
         done_q      <= 1'b0;
         reject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         alarm_cnt_q <= alarm_cnt_d;
         digits_q    <= digits_d;
         bal_q       <= bal_d;
         mode_q      <= mode_d;
         done_q      <= done_d;
         reject_q    <= reject_d;
      end
   end

   assign bal_out = bal_q;
   assign digits  = digits_q;
   assign done    = done_q;
   assign reject  = reject_q;
   assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign alarm   = (state_q == S_ALARM);

   always_comb begin
      case (state_q)
         S_IDLE:  st_light = 3'b001;
         S_RUN:   st_light = 3'b010;
         S_PAUSE: st_light = 3'b100;
         default: st_light = 3'b111;
      endcase
   end

endmodule

// File: tb/tb_wash_run.sv
// tb_wash_run: directed plus randomized bench for wash_run.
// A reference model tracks the job as remaining seconds, balance as an
// integer and the alarm as cycles left; outputs are compared every cycle.
module tb_wash_run;

   localparam int TICK  = 4;
   localparam int ALRM  = 6;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_ALARM = 3;

   logic        clk = 1'b0;
   logic        rst, start, pause, abort, is_on;
   logic [10:0] bal_in;
   logic [1:0]  mode;
   logic [4:0]  minutes;
   logic [10:0] bal_out;
   logic        busy, done, alarm, reject;
   logic [15:0] digits;
   logic [2:0]  st_light;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state.
   int m_state, m_secs, m_presc, m_alarm_left, m_bal, m_price;
   bit m_shown, m_done, m_reject;
   int prices[4] = '{1, 2, 3, 5};

   wash_run #(.TICK_CYC(TICK), .ALARM_CYC(ALRM)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
      .is_on(is_on), .bal_in(bal_in), .mode(mode), .minutes(minutes),
      .bal_out(bal_out), .busy(busy), .done(done), .alarm(alarm),
      .reject(reject), .digits(digits), .st_light(st_light)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_step();
      int cost;
      m_done   = 1'b0;
      m_reject = 1'b0;
      if (rst) begin
         m_state = M_IDLE; m_bal = 0; m_shown = 1'b0; m_presc = 0;
         m_alarm_left = 0; m_secs = 0;
      end else begin
         case (m_state)
            M_IDLE: if (start) begin
               cost = prices[mode] * int'(minutes);
               if (is_on && minutes >= 1 && minutes <= 29 && cost <= int'(bal_in)) begin
                  m_bal = int'(bal_in) - cost; m_secs = int'(minutes) * 60;
                  m_shown = 1'b1; m_presc = 0; m_price = prices[mode];
                  m_state = M_RUN;
               end else begin
                  m_reject = 1'b1; m_alarm_left = ALRM; m_state = M_ALARM;
               end
            end
            M_RUN: begin
               if (abort) begin
                  m_bal += m_price * (m_secs / 60); m_shown = 1'b0; m_state = M_IDLE;
               end else if (pause) begin
                  m_state = M_PAUSE;
               end else begin
                  m_presc++;
                  if (m_presc == TICK) begin
                     m_presc = 0; m_secs--;
                     if (m_secs == 0) begin
                        m_done = 1'b1; m_alarm_left = ALRM; m_state = M_ALARM;
                     end
                  end
               end
            end
            M_PAUSE: begin
               if (abort) begin
                  m_bal += m_price * (m_secs / 60); m_shown = 1'b0; m_state = M_IDLE;
               end else if (pause) begin
                  m_state = M_RUN;
               end
            end
            default: begin
               m_alarm_left--;
               if (m_alarm_left == 0) begin
                  m_state = M_IDLE; m_shown = 1'b0;
               end
            end
         endcase
      end
   endtask

   function automatic logic [15:0] exp_digits();
      int mm, ss;
      if (!m_shown) return 16'hbbbb;
      mm = m_secs / 60;
      ss = m_secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [2:0] exp_light();
      case (m_state)
         M_IDLE:  return 3'b001;
         M_RUN:   return 3'b010;
         M_PAUSE: return 3'b100;
         default: return 3'b111;
      endcase
   endfunction

   // One clock: model and DUT see the same inputs at the edge, outputs are
   // compared 1 time unit later, then the single-cycle pulses are cleared.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("bal_out",  16'(bal_out), 16'(m_bal[10:0]));
      chk("digits",   digits, exp_digits());
      chk("st_light", 16'(st_light), 16'(exp_light()));
      chk("busy",     16'(busy), 16'(m_state == M_RUN || m_state == M_PAUSE));
      chk("alarm",    16'(alarm), 16'(m_state == M_ALARM));
      chk("done",     16'(done), 16'(m_done));
      chk("reject",   16'(reject), 16'(m_reject));
      start = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0;
   endtask

   task automatic go(input int b, input int md, input int mn, input bit on);
      bal_in = 11'(b); mode = 2'(md); minutes = 5'(mn); is_on = on; start = 1'b1;
      cycle();
   endtask

   initial begin
      int dcount, acount;
      logic [15:0] frozen;
      int rej_min[3];
      bit rej_on[3];
      rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; is_on = 1'b0;
      bal_in = '0; mode = '0; minutes = '0;
      m_state = M_IDLE; m_bal = 0; m_shown = 1'b0; m_presc = 0;
      m_alarm_left = 0; m_secs = 0; m_price = 0;
      rst = 1'b1; cycle();
      rst = 1'b1; cycle();
      chk("rst_digits", digits, 16'hbbbb);
      chk("rst_light", 16'(st_light), 16'h0001);

      // Accept and full countdown.
      go(50, 1, 3, 1'b1);
      chk("acc_bal", 16'(bal_out), 16'd44);
      chk("acc_digits", digits, 16'h0300);
      chk("acc_light", 16'(st_light), 16'h0002);
      repeat (4) cycle();
      chk("first_tick", digits, 16'h0259);
      dcount = 0; acount = 0;
      repeat (730) begin
         cycle();
         dcount += int'(done);
         acount += int'(alarm);
      end
      chk("done_pulses", 16'(dcount), 16'd1);
      chk("alarm_cycles", 16'(acount), 16'd6);
      chk("end_blank", digits, 16'hbbbb);

      // Rejections: too expensive, zero minutes, 30 minutes, not on.
      go(10, 3, 3, 1'b1);
      chk("rej_pulse", 16'(reject), 16'd1);
      chk("rej_bal", 16'(bal_out), 16'd44);
      repeat (6) cycle();
      chk("rej_idle", 16'(st_light), 16'h0001);
      rej_min = '{0, 30, 5};
      rej_on  = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         go(500, 0, rej_min[i], rej_on[i]);
         chk("rej_case", 16'(reject), 16'd1);
         repeat (6) cycle();
      end

      // Pause holds the display for 20 cycles, then resumes.
      go(100, 0, 2, 1'b1);
      repeat (6) cycle();
      pause = 1'b1; cycle();
      chk("pause_light", 16'(st_light), 16'h0004);
      frozen = digits;
      repeat (20) cycle();
      chk("pause_frozen", digits, frozen);
      pause = 1'b1; cycle();
      repeat (12) cycle();
      abort = 1'b1; cycle();

      // Abort with refund at 07:30; pause in the same cycle loses.
      go(100, 2, 10, 1'b1);
      chk("abort_charge", 16'(bal_out), 16'd70);
      repeat (600) cycle();
      chk("abort_at", digits, 16'h0730);
      abort = 1'b1; pause = 1'b1; cycle();
      chk("abort_bal", 16'(bal_out), 16'd91);
      chk("abort_light", 16'(st_light), 16'h0001);

      // Abort on the final tick wins over done.
      go(5, 0, 1, 1'b1);
      repeat (239) cycle();
      chk("last_sec", digits, 16'h0001);
      abort = 1'b1; cycle();
      chk("final_abort_done", 16'(done), 16'd0);
      chk("final_abort_bal", 16'(bal_out), 16'd4);

      // Reset mid-run.
      go(200, 3, 4, 1'b1);
      repeat (10) cycle();
      rst = 1'b1; cycle();
      chk("rst_run_bal", 16'(bal_out), 16'd0);
      chk("rst_run_digits", digits, 16'hbbbb);

      // Randomized traffic.
      repeat (3000) begin
         start   = ($urandom_range(0, 19) == 0);
         pause   = ($urandom_range(0, 29) == 0);
         abort   = ($urandom_range(0, 199) == 0);
         is_on   = ($urandom_range(0, 7) != 0);
         bal_in  = 11'($urandom_range(0, 999));
         mode    = 2'($urandom_range(0, 3));
         minutes = 5'($urandom_range(0, 31));
         rst     = ($urandom_range(0, 1499) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
